sonic_v1_15_pcs_eth_10g_mac_rx_link_fault_detect: RTL and testbench

- Producer side of the MAC's 2-bit link-fault-status Avalon-ST stream.
- Monitors the 64-bit single-clock XGMII RX stream (two 32-bit columns per cycle) and runs the IEEE 802.3 clause 46 link fault state machine.
- Emits status changes on a ready/valid source that feeds the link-fault-status timing adapter/export path.

---
 rtl/sonic_v1_15_pcs_eth_10g_mac_rx_link_fault_detect_if.sv | 29 ++
 rtl/sonic_v1_15_pcs_eth_10g_mac_rx_link_fault_detect.sv | 115 +++++++++++
 tb/tb_sonic_v1_15_pcs_eth_10g_mac_rx_link_fault_detect.sv | 219 +++++++++++++++++++++
 3 files changed

// File: rtl/sonic_v1_15_pcs_eth_10g_mac_rx_link_fault_detect_if.sv
// Bundles the XGMII RX input stream and the 2-bit link-fault-status ready/valid source.
// master: the fault detector (consumes XGMII, drives out_valid/out_data, observes out_ready).
// slave : the environment (drives XGMII and out_ready, observes the status stream).
interface sonic_v1_15_pcs_eth_10g_mac_rx_link_fault_detect_if;
    logic [63:0] xgmii_rx_data;
    logic [7:0]  xgmii_rx_ctrl;
    logic        xgmii_rx_valid;
    logic        out_valid;
    logic        out_ready;
    logic [1:0]  out_data;

    modport master (
        input  xgmii_rx_data,
        input  xgmii_rx_ctrl,
        input  xgmii_rx_valid,
        input  out_ready,
        output out_valid,
        output out_data
    );

    modport slave (
        output xgmii_rx_data,
        output xgmii_rx_ctrl,
        output xgmii_rx_valid,
        output out_ready,
        input  out_valid,
        input  out_data
    );
endinterface

// File: rtl/sonic_v1_15_pcs_eth_10g_mac_rx_link_fault_detect.sv
// Purpose: link fault state machine over a 2-column XGMII RX stream; reports status changes.
// Latency: a status change caused by columns in cycle N is presented on out_valid/out_data in N+1.
// Backpressure: a pending change holds out_valid until accepted; newer changes overwrite out_data.
// Ports: clk, reset_n (sync, active-low); lf (master modport) carries XGMII in and the status stream.
module sonic_v1_15_pcs_eth_10g_mac_rx_link_fault_detect #(
    parameter int COL_WINDOW    = 128,
    parameter int SEQ_THRESHOLD = 4,
    parameter int CNT_W         = 8
) (
    input  logic clk,
    input  logic reset_n,
    sonic_v1_15_pcs_eth_10g_mac_rx_link_fault_detect_if.master lf
);

    localparam int               SEQ_W   = $clog2(SEQ_THRESHOLD + 1);
    localparam logic [SEQ_W-1:0] SEQ_MAX = SEQ_W'(SEQ_THRESHOLD);
    localparam logic [CNT_W-1:0] COL_MAX = CNT_W'(COL_WINDOW);

    localparam logic [1:0] ST_OK     = 2'b00;
    localparam logic [1:0] ST_LOCAL  = 2'b01;
    localparam logic [1:0] ST_REMOTE = 2'b10;

    typedef struct packed {
        logic [1:0]       fault;
        logic [1:0]       last_type;
        logic [SEQ_W-1:0] seq_cnt;
        logic [CNT_W-1:0] col_cnt;
    } lf_state_t;

    // Classify one 32-bit column: returns the fault type, or ST_OK for any ordinary column.
    function automatic logic [1:0] col_type(input logic [31:0] d, input logic [3:0] c);
        logic [1:0] t;
        t = ST_OK;
        if (c == 4'b0001 && d[7:0] == 8'h9C && d[15:8] == 8'h00 && d[23:16] == 8'h00) begin
            if (d[31:24] == 8'h01) begin
                t = ST_LOCAL;
            end else if (d[31:24] == 8'h02) begin
                t = ST_REMOTE;
            end
        end
        return t;
    endfunction

    // Advance the fault state by a single column of type t.
    function automatic lf_state_t col_step(input lf_state_t s, input logic [1:0] t);
        lf_state_t n;
        n = s;
        if (t != ST_OK) begin
            if (t == s.last_type && s.col_cnt < COL_MAX) begin
                if (s.seq_cnt < SEQ_MAX) begin
                    n.seq_cnt = s.seq_cnt + 1'b1;
                end
            end else begin
                n.seq_cnt   = SEQ_W'(1);
                n.last_type = t;
            end
            n.col_cnt = '0;
            // A held fault of the other type stays until this type reaches the threshold.
            if (n.seq_cnt == SEQ_MAX) begin
                n.fault = t;
            end
        end else if (s.col_cnt < COL_MAX) begin
            n.col_cnt = s.col_cnt + 1'b1;
            // Clear only on the column that reaches the window, not while saturated.
            if (n.col_cnt == COL_MAX) begin
                n.seq_cnt   = '0;
                n.last_type = ST_OK;
                n.fault     = ST_OK;
            end
        end
        return n;
    endfunction

    lf_state_t  st_q, st_d, st_mid;
    logic [1:0] type0, type1;
    logic       out_valid_q, out_valid_d;
    logic [1:0] out_data_q, out_data_d;
    logic       changed;

    always_comb begin
        type0  = col_type(lf.xgmii_rx_data[31:0],  lf.xgmii_rx_ctrl[3:0]);
        type1  = col_type(lf.xgmii_rx_data[63:32], lf.xgmii_rx_ctrl[7:4]);
        // Column 1 sees the state already updated by column 0.
        st_mid = col_step(st_q, type0);
        st_d   = lf.xgmii_rx_valid ? col_step(st_mid, type1) : st_q;

        // Only the end-of-cycle fault matters; a set-then-clear in one cycle is no change.
        changed     = (st_d.fault != st_q.fault);
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        if (changed) begin
            // Latest status wins; a simultaneous transfer consumed the previous value.
            out_valid_d = 1'b1;
            out_data_d  = st_d.fault;
        end else if (out_valid_q && lf.out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            st_q        <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= ST_OK;
        end else begin
            st_q        <= st_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
        end
    end

    assign lf.out_valid = out_valid_q;
    assign lf.out_data  = out_data_q;

endmodule

// File: tb/tb_sonic_v1_15_pcs_eth_10g_mac_rx_link_fault_detect.sv
module tb_sonic_v1_15_pcs_eth_10g_mac_rx_link_fault_detect;

    localparam int COL_WINDOW    = 128;
    localparam int SEQ_THRESHOLD = 4;

    // Column kinds used by the stimulus.
    localparam int K_IDLE   = 0;
    localparam int K_LOCAL  = 1;
    localparam int K_REMOTE = 2;
    localparam int K_BADL3  = 3;  // sequence-like, lane3 = 0x03
    localparam int K_BADCTL = 4;  // local sequence bytes with wrong ctrl nibble

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    sonic_v1_15_pcs_eth_10g_mac_rx_link_fault_detect_if lf();

    sonic_v1_15_pcs_eth_10g_mac_rx_link_fault_detect #(
        .COL_WINDOW(COL_WINDOW), .SEQ_THRESHOLD(SEQ_THRESHOLD), .CNT_W(8)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .lf(lf)
    );

    int n_total = 0;
    int n_pass  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    endtask

    // Behavioural model: unbounded gap / run counters, status stream state.
    int         m_gap;
    int         m_run;
    int         m_type;
    int         m_fault;
    logic       exp_valid;
    logic [1:0] exp_data;
    bit         model_on = 0;
    int         xfer_cnt = 0;
    logic [1:0] last_xfer;

    function automatic logic [35:0] col_bits(input int k);
        case (k)
            K_LOCAL:  return {4'h1, 32'h0100009C};
            K_REMOTE: return {4'h1, 32'h0200009C};
            K_BADL3:  return {4'h1, 32'h0300009C};
            K_BADCTL: return {4'h3, 32'h0100009C};
            default:  return {4'hF, 32'h07070707};
        endcase
    endfunction

    task automatic model_col(input int k);
        int t;
        t = (k == K_LOCAL) ? 1 : (k == K_REMOTE) ? 2 : 0;
        if (t != 0) begin
            if (t == m_type && m_gap < COL_WINDOW) m_run++;
            else begin
                m_run  = 1;
                m_type = t;
            end
            m_gap = 0;
            if (m_run >= SEQ_THRESHOLD) m_fault = t;
        end else begin
            m_gap++;
            if (m_gap == COL_WINDOW) begin
                m_run = 0; m_type = 0; m_fault = 0;
            end
        end
    endtask

    // One clock: apply inputs, wait for the edge, advance the model, settle 1 time unit.
    task automatic cyc(input int k0, input int k1, input bit v, input bit rst_n);
        logic [35:0] c0, c1;
        int   old_fault;
        bit   xfer;
        c0 = col_bits(k0);
        c1 = col_bits(k1);
        reset_n           = rst_n;
        lf.xgmii_rx_data  = {c1[31:0], c0[31:0]};
        lf.xgmii_rx_ctrl  = {c1[35:32], c0[35:32]};
        lf.xgmii_rx_valid = v;
        @(posedge clk);
        if (!rst_n) begin
            m_gap = 0; m_run = 0; m_type = 0; m_fault = 0;
            exp_valid = 1'b0; exp_data = 2'b00;
            model_on  = 1;
        end else begin
            old_fault = m_fault;
            xfer      = exp_valid && lf.out_ready;
            if (v) begin
                model_col(k0);
                model_col(k1);
            end
            if (m_fault != old_fault) begin
                exp_valid = 1'b1;
                exp_data  = 2'(m_fault);
            end else if (xfer) exp_valid = 1'b0;
        end
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(K_IDLE, K_IDLE, 1'b1, 1'b1);
    endtask

    // One sequence in column 1 followed by 10 idle columns.
    task automatic seq_gap(input int k);
        cyc(K_IDLE, k, 1'b1, 1'b1);
        idle(5);
    endtask

    // Compare process: DUT outputs against the model every cycle, plus transfer tracking.
    always @(negedge clk) begin
        if (model_on) begin
            check("out_valid", 32'(lf.out_valid), 32'(exp_valid));
            check("out_data",  32'(lf.out_data),  32'(exp_data));
            if (lf.out_valid && lf.out_ready) begin
                xfer_cnt++;
                last_xfer = lf.out_data;
            end
        end
    end

    int x0;

    initial begin
        lf.out_ready      = 1'b1;
        lf.xgmii_rx_data  = '0;
        lf.xgmii_rx_ctrl  = '0;
        lf.xgmii_rx_valid = 1'b0;
        cyc(K_IDLE, K_IDLE, 1'b1, 1'b0);
        cyc(K_IDLE, K_IDLE, 1'b1, 1'b0);
        check("reset_valid", 32'(lf.out_valid), 0);
        check("reset_data",  32'(lf.out_data),  0);

        // Local fault entry, interleaved with near-miss columns that must be ignored.
        x0 = xfer_cnt;
        for (int i = 0; i < 3; i++) seq_gap(K_LOCAL);
        cyc(K_BADL3, K_BADCTL, 1'b1, 1'b1);
        cyc(K_REMOTE, K_LOCAL, 1'b0, 1'b1);  // not valid: nothing counts
        check("entry_no_early", 32'(xfer_cnt - x0), 0);
        cyc(K_IDLE, K_LOCAL, 1'b1, 1'b1);
        check("entry_valid", 32'(lf.out_valid), 1);
        check("entry_data",  32'(lf.out_data),  1);
        idle(5);
        check("entry_one_pulse", 32'(xfer_cnt - x0), 1);

        // 127 idle columns then a local sequence: no change. Then 128 idle: clear.
        idle(58);
        x0 = xfer_cnt;
        cyc(K_IDLE, K_LOCAL, 1'b1, 1'b1);
        check("w127_no_change", 32'(xfer_cnt - x0), 0);
        check("w127_data", 32'(lf.out_data), 1);
        idle(63);
        check("clear_not_yet", 32'(lf.out_valid), 0);
        idle(1);
        check("clear_valid", 32'(lf.out_valid), 1);
        check("clear_data",  32'(lf.out_data),  0);
        idle(2);

        // Window miss for remote sequences.
        x0 = xfer_cnt;
        for (int i = 0; i < 3; i++) seq_gap(K_REMOTE);
        idle(65);
        for (int i = 0; i < 3; i++) seq_gap(K_REMOTE);
        check("miss_no_xfer", 32'(xfer_cnt - x0), 0);
        check("miss_data", 32'(lf.out_data), 0);
        cyc(K_REMOTE, K_IDLE, 1'b1, 1'b1);
        check("remote_data", 32'(lf.out_data), 2);
        idle(1);

        // Dual columns: type switch while remote is held, two cycles to reach local.
        cyc(K_LOCAL, K_LOCAL, 1'b1, 1'b1);
        check("dual_hold", 32'(lf.out_data), 2);
        cyc(K_LOCAL, K_LOCAL, 1'b1, 1'b1);
        check("dual_valid", 32'(lf.out_valid), 1);
        check("dual_data",  32'(lf.out_data),  1);
        idle(64);
        check("dual_clear", 32'(lf.out_data), 0);
        idle(2);

        // Backpressure: local then remote while not ready; one transfer of remote.
        lf.out_ready = 1'b0;
        x0 = xfer_cnt;
        cyc(K_LOCAL, K_LOCAL, 1'b1, 1'b1);
        cyc(K_LOCAL, K_LOCAL, 1'b1, 1'b1);
        idle(3);
        check("bp_hold_valid", 32'(lf.out_valid), 1);
        check("bp_hold_data",  32'(lf.out_data),  1);
        cyc(K_REMOTE, K_REMOTE, 1'b1, 1'b1);
        cyc(K_REMOTE, K_REMOTE, 1'b1, 1'b1);
        check("bp_latest_data", 32'(lf.out_data), 2);
        lf.out_ready = 1'b1;
        idle(1);
        check("bp_drop", 32'(lf.out_valid), 0);
        idle(2);
        check("bp_one_xfer", 32'(xfer_cnt - x0), 1);
        check("bp_xfer_data", 32'(last_xfer), 2);

        // Reset mid-sequence discards counts.
        for (int i = 0; i < 3; i++) seq_gap(K_LOCAL);
        cyc(K_IDLE, K_IDLE, 1'b1, 1'b0);
        check("rst_mid_valid", 32'(lf.out_valid), 0);
        check("rst_mid_data",  32'(lf.out_data),  0);
        seq_gap(K_LOCAL);
        check("rst_no_fault_v", 32'(lf.out_valid), 0);
        check("rst_no_fault_d", 32'(lf.out_data),  0);

        @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
